// File: rtl/servo_pulse_decoder.sv
// Servo pulse receiver: measures the high time of servo_in and decodes it to an 8-bit position.
// Optional macro SERVO_DEC_FILTER_EN adds a rounded 2-tap average on pos (+1 clk latency).
module servo_pulse_decoder #(
    parameter int unsigned MIN_PULSE_CYC    = 50000,
    parameter int unsigned STEP_CYC         = 196,
    parameter int unsigned GLITCH_CYC       = 25000,
    parameter int unsigned HIGH_TIMEOUT_CYC = 150000,
    parameter int unsigned LOSS_TIMEOUT_CYC = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       servo_in,
    output logic [7:0] pos,
    output logic       pos_valid,
    output logic       pulse_err,
    output logic       signal_lost
);

    localparam int W_W = $clog2(HIGH_TIMEOUT_CYC + 1);
    localparam int P_W = $clog2(STEP_CYC + 1);
    localparam int L_W = $clog2(LOSS_TIMEOUT_CYC + 1);

    localparam logic [W_W-1:0] MIN_W     = W_W'(MIN_PULSE_CYC);
    localparam logic [W_W-1:0] GLITCH_W  = W_W'(GLITCH_CYC);
    localparam logic [W_W-1:0] HIGH_TO_W = W_W'(HIGH_TIMEOUT_CYC);
    localparam logic [P_W-1:0] STEP_LAST = P_W'(STEP_CYC - 1);
    localparam logic [L_W-1:0] LOSS_MAX  = L_W'(LOSS_TIMEOUT_CYC);
    localparam logic [L_W-1:0] LOSS_LAST = L_W'(LOSS_TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOW  = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2
    } state_t;

    logic           sync1_r, sync2_r, prev_r, rise_r, fall_r;
    state_t         state_r, state_nx_s;
    logic [W_W-1:0] width_r, width_nx_s;
    logic [P_W-1:0] presc_r, presc_nx_s;
    logic [7:0]     steps_r, steps_nx_s;
    logic           dec_valid_s, dec_err_s;
    logic [7:0]     dec_pos_s;
    logic           out_valid_s, out_err_s;
    logic [7:0]     out_pos_s;
    logic [7:0]     pos_r;
    logic           pos_valid_r, pulse_err_r, signal_lost_r;
    logic [L_W-1:0] loss_cnt_r;

    // Synchronizer and registered edge detector. Resetting to 1 makes a line that is
    // already high at reset release look like a steady high, not a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= servo_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
            fall_r  <= ~sync2_r & prev_r;
        end
    end

    // FSM state and measurement counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_WAIT_LOW;
            width_r <= '0;
            presc_r <= '0;
            steps_r <= 8'd0;
        end else begin
            state_r <= state_nx_s;
            width_r <= width_nx_s;
            presc_r <= presc_nx_s;
            steps_r <= steps_nx_s;
        end
    end

    // Next state, width/step counting and decode of a finished pulse.
    always_comb begin
        state_nx_s  = state_r;
        width_nx_s  = width_r;
        presc_nx_s  = presc_r;
        steps_nx_s  = steps_r;
        dec_valid_s = 1'b0;
        dec_err_s   = 1'b0;
        dec_pos_s   = 8'd0;
        case (state_r)
            ST_WAIT_LOW: begin
                if (!sync2_r) begin
                    state_nx_s = ST_WAIT_RISE;
                end else begin
                    state_nx_s = ST_WAIT_LOW;
                end
            end
            ST_WAIT_RISE: begin
                if (rise_r) begin
                    state_nx_s = ST_MEASURE;
                    width_nx_s = W_W'(1);
                    presc_nx_s = '0;
                    steps_nx_s = 8'd0;
                end else begin
                    state_nx_s = ST_WAIT_RISE;
                end
            end
            ST_MEASURE: begin
                if (fall_r) begin
                    state_nx_s = ST_WAIT_RISE;
                    width_nx_s = '0;
                    if (width_r < GLITCH_W) begin
                        dec_err_s = 1'b1;
                    end else if (width_r < MIN_W) begin
                        dec_valid_s = 1'b1;
                        dec_pos_s   = 8'd0;
                    end else begin
                        dec_valid_s = 1'b1;
                        dec_pos_s   = steps_r;
                    end
                end else if (width_r >= HIGH_TO_W) begin
                    // Still high with the counter at the limit: this cycle is width limit+1.
                    dec_err_s  = 1'b1;
                    state_nx_s = ST_WAIT_LOW;
                    width_nx_s = '0;
                end else begin
                    width_nx_s = width_r + W_W'(1);
                    if (width_r >= MIN_W) begin
                        if (presc_r == STEP_LAST) begin
                            presc_nx_s = '0;
                            if (steps_r != 8'hFF) begin
                                steps_nx_s = steps_r + 8'd1;
                            end else begin
                                steps_nx_s = steps_r;
                            end
                        end else begin
                            presc_nx_s = presc_r + P_W'(1);
                        end
                    end else begin
                        presc_nx_s = presc_r;
                    end
                end
            end
            default: begin
                state_nx_s = ST_WAIT_LOW;
            end
        endcase
    end

`ifdef SERVO_DEC_FILTER_EN
    logic       stg_valid_r, stg_err_r;
    logic [7:0] stg_pos_r;

    // Extra stage so the average is formed against the previously published pos.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid_r <= 1'b0;
            stg_err_r   <= 1'b0;
            stg_pos_r   <= 8'd0;
        end else begin
            stg_valid_r <= dec_valid_s;
            stg_err_r   <= dec_err_s;
            stg_pos_r   <= dec_pos_s;
        end
    end

    // A decode after reset or after loss of signal has no valid history to average with.
    always_comb begin
        out_valid_s = stg_valid_r;
        out_err_s   = stg_err_r;
        if (signal_lost_r) begin
            out_pos_s = stg_pos_r;
        end else begin
            out_pos_s = 8'(({1'b0, pos_r} + {1'b0, stg_pos_r} + 9'd1) >> 1);
        end
    end
`else
    // Unfiltered: publish the decode directly.
    always_comb begin
        out_valid_s = dec_valid_s;
        out_err_s   = dec_err_s;
        out_pos_s   = dec_pos_s;
    end
`endif

    // Output registers and loss-of-signal timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_r         <= 8'd0;
            pos_valid_r   <= 1'b0;
            pulse_err_r   <= 1'b0;
            signal_lost_r <= 1'b1;
            loss_cnt_r    <= '0;
        end else begin
            pos_valid_r <= out_valid_s;
            pulse_err_r <= out_err_s & ~out_valid_s;
            if (out_valid_s) begin
                pos_r         <= out_pos_s;
                loss_cnt_r    <= '0;
                signal_lost_r <= 1'b0;
            end else begin
                if (loss_cnt_r != LOSS_MAX) begin
                    loss_cnt_r <= loss_cnt_r + L_W'(1);
                end else begin
                    loss_cnt_r <= loss_cnt_r;
                end
                if (loss_cnt_r >= LOSS_LAST) begin
                    signal_lost_r <= 1'b1;
                end else begin
                    signal_lost_r <= signal_lost_r;
                end
            end
        end
    end

    assign pos         = pos_r;
    assign pos_valid   = pos_valid_r;
    assign pulse_err   = pulse_err_r;
    assign signal_lost = signal_lost_r;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Scoreboard bench for servo_pulse_decoder (default build, filter off).
module tb_servo_pulse_decoder;

    localparam int MIN    = 1000;
    localparam int STEP   = 4;
    localparam int GLITCH = 500;
    localparam int HTO    = 4000;
    localparam int LOSS   = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic       servo_in;
    logic [7:0] pos;
    logic       pos_valid;
    logic       pulse_err;
    logic       signal_lost;

    servo_pulse_decoder #(
        .MIN_PULSE_CYC   (MIN),
        .STEP_CYC        (STEP),
        .GLITCH_CYC      (GLITCH),
        .HIGH_TIMEOUT_CYC(HTO),
        .LOSS_TIMEOUT_CYC(LOSS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .servo_in   (servo_in),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .pulse_err  (pulse_err),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] pos;
        int         at;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per output event.
    always @(negedge clk) begin
        if (!rst && (pos_valid || pulse_err)) begin
            exp_t e;
            check("exclusive", int'(pos_valid & pulse_err), 0);
            if (sb.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                e = sb.pop_front();
                check("event_kind", int'(pulse_err), int'(e.is_err));
                check("event_cycle", cyc, e.at);
                check("pos", int'(pos), int'(e.pos));
                if (!e.is_err) check("lost_clear", int'(signal_lost), 0);
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 valid decode, 1 glitch reject, 2 overlong reject. p = pos expected at the event.
    task automatic pulse(int n, int kind, logic [7:0] p);
        exp_t e;
        int   r;
        servo_in = 1'b1;
        r = cyc;
        e.is_err = (kind != 0);
        e.pos    = p;
        e.at     = (kind == 2) ? r + HTO + 4 : r + n + 4;
        sb.push_back(e);
        idle(n);
        servo_in = 1'b0;
    endtask

    task automatic do_reset(logic lvl);
        servo_in = lvl;
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        check("rst_pos", int'(pos), 0);
        check("rst_valid", int'(pos_valid), 0);
        check("rst_err", int'(pulse_err), 0);
        check("rst_lost", int'(signal_lost), 1);
    endtask

    initial begin
        rst = 1'b1;
        servo_in = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0);
        idle(100);
        check("lost_before_first", int'(signal_lost), 1);

        // Basic decode, saturation by range
        pulse(1000, 0, 8'd0);
        idle(8000);
        check("lost_after_first", int'(signal_lost), 0);
        pulse(1400, 0, 8'd100);
        idle(8000);
        pulse(2020, 0, 8'd255);
        idle(8000);

        // Saturation on long pulse, below-min pulse decodes to 0
        pulse(3000, 0, 8'd255);
        idle(1000);
        pulse(700, 0, 8'd0);
        idle(1000);

        // Glitch and overlong rejects hold pos
        pulse(200, 1, 8'd0);
        idle(1000);
        pulse(5000, 2, 8'd0);
        idle(1000);
        pulse(1400, 0, 8'd100);
        idle(1000);

        // Pulse already high at reset release is ignored
        do_reset(1'b1);
        idle(300);
        servo_in = 1'b0;
        idle(1000);
        check("stale_ignored", sb.size(), 0);
        pulse(1200, 0, 8'd50);
        idle(1000);

        // Loss of signal and recovery
        pulse(1400, 0, 8'd100);
        idle(19990);
        check("lost_not_yet", int'(signal_lost), 0);
        idle(20);
        check("lost_set", int'(signal_lost), 1);
        check("pos_held", int'(pos), 100);
        pulse(1200, 0, 8'd50);
        idle(1000);
        check("lost_cleared", int'(signal_lost), 0);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
